// File: rtl/ifetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_prefetch_queue
//
// Instruction-fetch front end. It owns the fetch PC, issues ready/valid
// requests to IMEM and buffers up to DEPTH fetched {pc, instr} pairs in a
// circular queue so that IMEM wait states and decode stalls are decoupled.
// A redirect from Execute flushes the queue and retargets the fetch PC. If an
// IMEM request is in flight at that moment, the request is completed at its
// original address (KILL state) and its response is dropped.
//
// All outputs are registered. Each output register is loaded with the value
// the output must show after the edge, which is derived from the next-state
// signals.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   imem_A         out  fetch address (held stable while a request waits)
//   imem_read      out  fetch request
//   imem_ready     in   IMEM completes the request this cycle
//   imem_RD        in   fetched instruction word, valid with imem_ready
//   redirect_valid in   taken branch/jump from Execute
//   redirect_pc    in   redirect target (bits [1:0] ignored)
//   instr_valid    out  queue head is valid
//   instr_ready    in   decode accepts the head
//   instr_out      out  head instruction
//   pc_out         out  head PC
//   pcplus4_out    out  head PC + 4 (modulo 2^32)
//   count          out  queue occupancy
// -----------------------------------------------------------------------------
module ifetch_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic [31:0]              imem_A,
   output logic                     imem_read,
   input  logic                     imem_ready,
   input  logic [31:0]              imem_RD,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [31:0]              instr_out,
   output logic [31:0]              pc_out,
   output logic [31:0]              pcplus4_out,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_STEP   = PTR_W'(1'b1);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_KILL = 1'b1
   } fetch_state_t;

   // architectural state
   fetch_state_t       state_r;
   logic               started_r;
   logic [31:0]        fetch_pc_r;
   logic [31:0]        kill_pc_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic [31:0]        q_pc_r    [DEPTH];
   logic [31:0]        q_instr_r [DEPTH];

   // output registers
   logic [31:0]        imem_a_r;
   logic               imem_read_r;
   logic               instr_valid_r;
   logic [31:0]        instr_out_r;
   logic [31:0]        pc_out_r;
   logic [31:0]        pcplus4_out_r;

   // next-state / control signals
   fetch_state_t       state_s;
   logic [31:0]        fetch_pc_s;
   logic [31:0]        kill_pc_s;
   logic [31:0]        redirect_target_s;
   logic               clear_s;
   logic               push_s;
   logic               pop_s;
   logic [PTR_W-1:0]   rd_ptr_s;
   logic [PTR_W-1:0]   wr_ptr_s;
   logic [CNT_W-1:0]   count_s;
   logic [31:0]        head_pc_s;
   logic [31:0]        head_instr_s;
   logic [31:0]        imem_a_s;
   logic               imem_read_s;

   // Word-aligned redirect target; the low two address bits are dropped.
   assign redirect_target_s = redirect_pc & 32'hFFFF_FFFC;

   // FSM next state, fetch PC update and push/pop/clear decisions.
   always_comb begin
      state_s    = state_r;
      fetch_pc_s = fetch_pc_r;
      kill_pc_s  = kill_pc_r;
      clear_s    = 1'b0;
      push_s     = 1'b0;
      pop_s      = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (redirect_valid) begin
               // Redirect wins over any push or pop this cycle.
               clear_s    = 1'b1;
               fetch_pc_s = redirect_target_s;
               if (imem_read_r && !imem_ready) begin
                  // Request still waiting: finish it at the old address.
                  kill_pc_s = imem_a_r;
                  state_s   = ST_KILL;
               end else begin
                  state_s   = ST_RUN;
               end
            end else begin
               push_s = started_r && imem_read_r && imem_ready;
               pop_s  = instr_valid_r && instr_ready;
               if (push_s) begin
                  fetch_pc_s = fetch_pc_r + 32'd4;
               end else begin
                  fetch_pc_s = fetch_pc_r;
               end
            end
         end
         ST_KILL: begin
            // The queue stays empty; only the latest redirect target matters.
            if (redirect_valid) begin
               fetch_pc_s = redirect_target_s;
            end else begin
               fetch_pc_s = fetch_pc_r;
            end
            if (imem_ready) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_KILL;
            end
         end
         default: begin
            state_s = ST_RUN;
         end
      endcase
   end

   // Queue pointer and occupancy update.
   always_comb begin
      rd_ptr_s = rd_ptr_r;
      wr_ptr_s = wr_ptr_r;
      count_s  = count_r;
      if (clear_s) begin
         rd_ptr_s = '0;
         wr_ptr_s = '0;
         count_s  = '0;
      end else begin
         if (push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_STEP;
         end else begin
            wr_ptr_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_STEP;
         end else begin
            rd_ptr_s = rd_ptr_r;
         end
         count_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // Values the output registers must present after this edge.
   always_comb begin
      head_pc_s    = q_pc_r[rd_ptr_s];
      head_instr_s = q_instr_r[rd_ptr_s];
      // The slot being written this edge becomes the head when the queue
      // was empty (or drains down to it), so forward the incoming entry.
      if (push_s && (wr_ptr_r == rd_ptr_s)) begin
         head_pc_s    = fetch_pc_r;
         head_instr_s = imem_RD;
      end else begin
         head_pc_s    = q_pc_r[rd_ptr_s];
         head_instr_s = q_instr_r[rd_ptr_s];
      end
      if (state_s == ST_KILL) begin
         imem_a_s    = kill_pc_s;
         imem_read_s = 1'b1;
      end else begin
         // A request never starts while full, so a full queue is never pushed.
         imem_a_s    = fetch_pc_s;
         imem_read_s = (count_s < FULL_COUNT);
      end
   end

   // Control state, pointers and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_RUN;
         started_r     <= 1'b0;
         fetch_pc_r    <= RESET_PC;
         kill_pc_r     <= RESET_PC;
         rd_ptr_r      <= '0;
         wr_ptr_r      <= '0;
         count_r       <= '0;
         imem_a_r      <= RESET_PC;
         imem_read_r   <= 1'b0;
         instr_valid_r <= 1'b0;
         instr_out_r   <= 32'd0;
         pc_out_r      <= 32'd0;
         pcplus4_out_r <= 32'd4;
      end else begin
         state_r       <= state_s;
         started_r     <= 1'b1;
         fetch_pc_r    <= fetch_pc_s;
         kill_pc_r     <= kill_pc_s;
         rd_ptr_r      <= rd_ptr_s;
         wr_ptr_r      <= wr_ptr_s;
         count_r       <= count_s;
         // The reset value of imem_read_r gives the one-cycle start delay.
         imem_a_r      <= imem_a_s;
         imem_read_r   <= imem_read_s;
         instr_valid_r <= (count_s != '0);
         instr_out_r   <= head_instr_s;
         pc_out_r      <= head_pc_s;
         pcplus4_out_r <= head_pc_s + 32'd4;
      end
   end

   // Queue storage: one entry written per accepted IMEM response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_pc_r[i]    <= 32'd0;
            q_instr_r[i] <= 32'd0;
         end
      end else begin
         if (push_s) begin
            q_pc_r[wr_ptr_r]    <= fetch_pc_r;
            q_instr_r[wr_ptr_r] <= imem_RD;
         end
      end
   end

   assign imem_A      = imem_a_r;
   assign imem_read   = imem_read_r;
   assign instr_valid = instr_valid_r;
   assign instr_out   = instr_out_r;
   assign pc_out      = pc_out_r;
   assign pcplus4_out = pcplus4_out_r;
   assign count       = count_r;

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// Testbench for ifetch_prefetch_queue.
// dut1: DEPTH=4, RESET_PC=0. dut2: DEPTH=4, RESET_PC=0xFFFF_FFF8 (wrap case).
// Both share the stimulus. dut1 is compared every cycle against a queue-level
// reference model; fixed vector tables and hand-written sequences add
// absolute expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_ifetch_prefetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_RD = 32'd0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        instr_ready = 1'b0;

   logic [31:0] a1, instr1, pc1, pcp1;
   logic        read1, valid1;
   logic [2:0]  count1;
   logic [31:0] a2, instr2, pc2, pcp2;
   logic        read2, valid2;
   logic [2:0]  count2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .imem_A(a1), .imem_read(read1), .imem_ready(imem_ready), .imem_RD(imem_RD),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(valid1), .instr_ready(instr_ready), .instr_out(instr1),
      .pc_out(pc1), .pcplus4_out(pcp1), .count(count1)
   );

   ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .imem_A(a2), .imem_read(read2), .imem_ready(imem_ready), .imem_RD(imem_RD),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(valid2), .instr_ready(instr_ready), .instr_out(instr2),
      .pc_out(pc2), .pcplus4_out(pcp2), .count(count2)
   );

   // ---------------- reference model (dut1) ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      mq[$];
   logic [31:0] m_fetch;
   logic [31:0] m_kill_addr;
   bit          m_killing;
   bit          m_started;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_read();
      if (m_killing) return 1'b1;
      return m_started && (mq.size() < DEPTH);
   endfunction

   task automatic model_check();
      logic [31:0] ea;
      ea = m_killing ? m_kill_addr : m_fetch;
      chk("model_imem_read", 32'(read1), 32'(model_read()));
      chk("model_imem_A", a1, ea);
      chk("model_count", 32'(count1), 32'(mq.size()));
      chk("model_instr_valid", 32'(valid1), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("model_pc_out", pc1, mq[0].pc);
         chk("model_instr_out", instr1, mq[0].instr);
         chk("model_pcplus4_out", pcp1, mq[0].pc + 32'd4);
      end
   endtask

   task automatic model_update();
      bit     er;
      entry_t e;
      er = model_read();
      if (m_killing) begin
         if (redirect_valid) m_fetch = {redirect_pc[31:2], 2'b00};
         if (imem_ready) m_killing = 1'b0;
      end else if (redirect_valid) begin
         mq.delete();
         if (er && !imem_ready) begin
            m_killing   = 1'b1;
            m_kill_addr = m_fetch;
         end
         m_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
         if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
         if (er && imem_ready) begin
            e.pc    = m_fetch;
            e.instr = imem_RD;
            mq.push_back(e);
            m_fetch = m_fetch + 32'd4;
         end
      end
      m_started = 1'b1;
   endtask

   // ---------------- cycle helpers ----------------
   task automatic apply(input bit rdy, input logic [31:0] rd, input bit rv,
                        input logic [31:0] rp, input bit ir);
      imem_ready     = rdy;
      imem_RD        = rd;
      redirect_valid = rv;
      redirect_pc    = rp;
      instr_ready    = ir;
   endtask

   task automatic finish_cycle();
      #1;
      model_check();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input bit rdy, input logic [31:0] rd, input bit rv,
                       input logic [31:0] rp, input bit ir);
      apply(rdy, rd, rv, rp, ir);
      finish_cycle();
   endtask

   task automatic do_reset();
      apply(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_instr_valid", 32'(valid1), 32'd0);
      chk("rst_imem_read", 32'(read1), 32'd0);
      chk("rst_imem_A", a1, 32'h0000_0000);
      chk("rst_count", 32'(count1), 32'd0);
      chk("rst_instr_out", instr1, 32'd0);
      chk("rst_pc_out", pc1, 32'd0);
      chk("rst_pcplus4_out", pcp1, 32'd4);
      chk("rst2_imem_A", a2, 32'hFFFF_FFF8);
      chk("rst2_imem_read", 32'(read2), 32'd0);
      @(posedge clk);
      @(negedge clk);
      mq.delete();
      m_fetch     = 32'h0000_0000;
      m_kill_addr = 32'h0000_0000;
      m_killing   = 1'b0;
      m_started   = 1'b0;
      rst_n = 1'b1;
   endtask

   // ---------------- vector table: streaming + backpressure ----------------
   typedef struct {
      bit          rdy;
      bit          ir;
      bit          e_valid;
      bit          e_read;
      logic [31:0] e_a;
      int          e_cnt;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vt[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // imem_RD in row k is 32'hC0DE_0000 + k
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 0, 32'h00, 32'h0};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 0, 32'h00, 32'h0};
      vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h04, 1, 32'h00, 32'hC0DE_0001};
      vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 2, 32'h00, 32'hC0DE_0001};
      vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 3, 32'h00, 32'hC0DE_0001};
      vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 4, 32'h00, 32'hC0DE_0001};
      vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 3, 32'h04, 32'hC0DE_0002};
      vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 3, 32'h08, 32'hC0DE_0003};
      vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 2, 32'h0C, 32'hC0DE_0004};
      vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1, 32'h10, 32'hC0DE_0006};
      vt[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 1, 32'h14, 32'hC0DE_0009};
      vt[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1C, 1, 32'h18, 32'hC0DE_000A};

      @(negedge clk);
      do_reset();

      for (int k = 0; k < 12; k++) begin
         apply(vt[k].rdy, 32'hC0DE_0000 + 32'(k), 1'b0, 32'd0, vt[k].ir);
         #1;
         chk("vec_instr_valid", 32'(valid1), 32'(vt[k].e_valid));
         chk("vec_imem_read", 32'(read1), 32'(vt[k].e_read));
         chk("vec_imem_A", a1, vt[k].e_a);
         chk("vec_count", 32'(count1), 32'(vt[k].e_cnt));
         if (vt[k].e_valid) begin
            chk("vec_pc_out", pc1, vt[k].e_pc);
            chk("vec_instr_out", instr1, vt[k].e_instr);
            chk("vec_pcplus4_out", pcp1, vt[k].e_pc + 32'd4);
         end
         finish_cycle();
      end

      // ---- redirect while a request waits ----
      do_reset();
      for (int k = 0; k < 5; k++) step(1'b1, 32'hAA00_0000 + 32'(k), 1'b0, 32'd0, 1'b1);
      chk("kill_A_before", a1, 32'h10);
      step(1'b0, 32'hBAD0_0010, 1'b1, 32'h200, 1'b1);
      chk("kill_A_hold1", a1, 32'h10);
      chk("kill_read_hold1", 32'(read1), 32'd1);
      chk("kill_count_cleared", 32'(count1), 32'd0);
      step(1'b0, 32'hBAD0_0010, 1'b0, 32'd0, 1'b1);
      chk("kill_A_hold2", a1, 32'h10);
      step(1'b0, 32'hBAD0_0010, 1'b0, 32'd0, 1'b1);
      chk("kill_A_hold3", a1, 32'h10);
      step(1'b1, 32'hBAD0_0010, 1'b0, 32'd0, 1'b1);
      chk("kill_A_new", a1, 32'h200);
      chk("kill_no_push", 32'(count1), 32'd0);
      step(1'b1, 32'h1234_0200, 1'b0, 32'd0, 1'b1);
      chk("kill_first_pc", pc1, 32'h200);
      chk("kill_first_instr", instr1, 32'h1234_0200);

      // ---- redirect together with imem_ready and a pop ----
      do_reset();
      step(1'b1, 32'h5500_0000, 1'b0, 32'd0, 1'b1);
      step(1'b1, 32'h5500_0001, 1'b0, 32'd0, 1'b1);
      chk("coinc_valid_before", 32'(valid1), 32'd1);
      step(1'b1, 32'h5500_0002, 1'b1, 32'h200, 1'b1);
      chk("coinc_count", 32'(count1), 32'd0);
      chk("coinc_valid", 32'(valid1), 32'd0);
      chk("coinc_A", a1, 32'h200);
      chk("coinc_read", 32'(read1), 32'd1);
      step(1'b1, 32'h5500_0003, 1'b0, 32'd0, 1'b0);

      // ---- double redirect in KILL ----
      do_reset();
      step(1'b1, 32'h6600_0000, 1'b0, 32'd0, 1'b1);
      step(1'b0, 32'h6600_0001, 1'b1, 32'h300, 1'b1);
      chk("dbl_A_kill", a1, 32'h0);
      step(1'b0, 32'h6600_0002, 1'b1, 32'h403, 1'b1);
      chk("dbl_A_kill2", a1, 32'h0);
      step(1'b1, 32'h6600_0003, 1'b0, 32'd0, 1'b1);
      chk("dbl_A_new", a1, 32'h400);
      chk("dbl_read_new", 32'(read1), 32'd1);
      step(1'b1, 32'h6600_0400, 1'b0, 32'd0, 1'b1);
      chk("dbl_first_pc", pc1, 32'h400);

      // ---- address wrap-around (dut2) ----
      do_reset();
      step(1'b1, 32'h7700_0000, 1'b0, 32'd0, 1'b0);
      chk("wrap_A0", a2, 32'hFFFF_FFF8);
      step(1'b1, 32'h7700_0001, 1'b0, 32'd0, 1'b0);
      chk("wrap_A1", a2, 32'hFFFF_FFFC);
      chk("wrap_head0_pc", pc2, 32'hFFFF_FFF8);
      step(1'b1, 32'h7700_0002, 1'b0, 32'd0, 1'b0);
      chk("wrap_A2", a2, 32'h0000_0000);
      step(1'b1, 32'h7700_0003, 1'b0, 32'd0, 1'b1);
      chk("wrap_head1_pc", pc2, 32'hFFFF_FFFC);
      chk("wrap_head1_pcplus4", pcp2, 32'h0000_0000);
      chk("wrap_head1_instr", instr2, 32'h7700_0002);

      // ---- randomized traffic against the model ----
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ((i % 700) == 699) begin
            do_reset();
         end else begin
            step($urandom_range(0, 9) < 6, $urandom(), $urandom_range(0, 11) == 0,
                 $urandom(), $urandom_range(0, 9) < 7);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
